// File: rtl/snake_dir_input.sv
// Player-1 steering conditioner: synchronizes and debounces the four pushbuttons,
// turns presses into direction requests, and commits them on the game-step tick.
module snake_dir_input #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 20,
    parameter logic [2:0]  IDLE_DIR        = 3'd5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       up_n,
    input  logic       right_n,
    input  logic       down_n,
    input  logic       left_n,
    input  logic       tick,
    output logic [2:0] dir_out,
    output logic [2:0] dir_pending,
    output logic       dir_valid,
    output logic       dir_changed,
    output logic [3:0] btn_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       pad_n;
    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [3:0]       lvl_p2;
    logic [3:0]       lvl_p3;
    logic [CNT_W-1:0] cnt_p2 [4];
    logic [3:0]       press_evt;
    logic             cand_vld;
    logic [2:0]       cand_dir;
    logic [2:0]       ref_dir;
    logic             accept;

    function automatic logic [2:0] opposite(input logic [2:0] d);
        case (d)
            3'd1:    opposite = 3'd3;
            3'd2:    opposite = 3'd4;
            3'd3:    opposite = 3'd1;
            3'd4:    opposite = 3'd2;
            default: opposite = IDLE_DIR;
        endcase
    endfunction

    function automatic logic [2:0] pick_dir(input logic [3:0] evt);
        if (evt[0])      pick_dir = 3'd1;
        else if (evt[1]) pick_dir = 3'd2;
        else if (evt[2]) pick_dir = 3'd3;
        else             pick_dir = 3'd4;
    endfunction

    assign pad_n = {left_n, down_n, right_n, up_n};

    // Stage 0/1: two-flop synchronizer, active-low domain
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_p0 <= 4'hF;
            sync_p1 <= 4'hF;
        end else begin
            sync_p0 <= pad_n;
            sync_p1 <= sync_p0;
        end
    end

    // Stage 2/3: debounce to pressed-level, plus one-cycle delay for edge detection
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lvl_p2 <= 4'h0;
            lvl_p3 <= 4'h0;
            for (int i = 0; i < 4; i++) cnt_p2[i] <= '0;
        end else begin
            lvl_p3 <= lvl_p2;
            for (int i = 0; i < 4; i++) begin
                if (~sync_p1[i] == lvl_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_LAST) begin
                    lvl_p2[i] <= ~sync_p1[i];
                    cnt_p2[i] <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_level = lvl_p2;
    assign press_evt = lvl_p2 & ~lvl_p3;

    // Reversal is judged against what dir_out will hold after this edge
    always_comb begin
        cand_vld = |press_evt;
        cand_dir = pick_dir(press_evt);
        ref_dir  = tick ? dir_pending : dir_out;
        accept   = cand_vld && ((ref_dir == IDLE_DIR) || (cand_dir != opposite(ref_dir)));
    end

    // Stage 4: pending request and tick commit
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dir_out     <= IDLE_DIR;
            dir_pending <= IDLE_DIR;
            dir_valid   <= 1'b0;
            dir_changed <= 1'b0;
        end else begin
            if (accept) begin
                dir_pending <= cand_dir;
            end
            if (tick) begin
                dir_out     <= dir_pending;
                dir_changed <= (dir_pending != dir_out);
                dir_valid   <= dir_valid | (dir_pending != IDLE_DIR);
            end else begin
                dir_changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_snake_dir_input.sv
// Bench for snake_dir_input: directed scenarios plus random button/tick traffic,
// all outputs compared every cycle against a window-based reference model.
module tb_snake_dir_input;

    logic       clock;
    logic       resetn;
    logic [3:0] pad_n;
    logic       tick;
    logic [2:0] dir_out;
    logic [2:0] dir_pending;
    logic       dir_valid;
    logic       dir_changed;
    logic [3:0] btn_level;

    int n_checks = 0;
    int n_errors = 0;

    snake_dir_input #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .IDLE_DIR(3'd5)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .up_n(pad_n[0]),
        .right_n(pad_n[1]),
        .down_n(pad_n[2]),
        .left_n(pad_n[3]),
        .tick(tick),
        .dir_out(dir_out),
        .dir_pending(dir_pending),
        .dir_valid(dir_valid),
        .dir_changed(dir_changed),
        .btn_level(btn_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pad history delayed two samples, a button's pressed level
    // flips once the last four synced samples all disagree with it.
    logic [3:0] m_s1, m_s2, m_lvl, m_lvl_d;
    logic [3:0] m_win [4];
    int         m_out, m_pend;
    logic       m_val, m_chg;

    function automatic int opp_dir(input int d);
        return ((d + 1) % 4) + 1;
    endfunction

    always @(posedge clock or negedge resetn) begin
        logic [3:0] evt;
        logic [3:0] nlvl;
        logic [3:0] nwin [4];
        int         cand, refd, npend;
        logic       all_diff;
        if (!resetn) begin
            m_s1 <= 4'h0; m_s2 <= 4'h0; m_lvl <= 4'h0; m_lvl_d <= 4'h0;
            for (int k = 0; k < 4; k++) m_win[k] <= 4'h0;
            m_out <= 5; m_pend <= 5; m_val <= 1'b0; m_chg <= 1'b0;
        end else begin
            evt  = m_lvl & ~m_lvl_d;
            cand = 0;
            for (int b = 3; b >= 0; b--) if (evt[b]) cand = b + 1;
            refd  = tick ? m_pend : m_out;
            npend = m_pend;
            if (cand != 0 && (refd == 5 || cand != opp_dir(refd))) npend = cand;
            if (tick) begin
                m_chg <= (m_pend != m_out);
                m_out <= m_pend;
                m_val <= (m_pend != 5);
            end else begin
                m_chg <= 1'b0;
            end
            m_pend <= npend;
            nwin[0] = m_s2;
            for (int k = 1; k < 4; k++) nwin[k] = m_win[k-1];
            nlvl = m_lvl;
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < 4; k++) if (nwin[k][b] == m_lvl[b]) all_diff = 1'b0;
                if (all_diff) nlvl[b] = ~m_lvl[b];
            end
            for (int k = 0; k < 4; k++) m_win[k] <= nwin[k];
            m_lvl_d <= m_lvl;
            m_lvl   <= nlvl;
            m_s2    <= m_s1;
            m_s1    <= ~pad_n;
        end
    end

    always @(negedge clock) begin
        check("dir_out", 32'(dir_out), 32'(m_out));
        check("dir_pending", 32'(dir_pending), 32'(m_pend));
        check("dir_valid", 32'(dir_valid), 32'(m_val));
        check("dir_changed", 32'(dir_changed), 32'(m_chg));
        check("btn_level", 32'(btn_level), 32'(m_lvl));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    task automatic press_release(input int b, input int hold);
        pad_n[b] = 1'b0;
        cyc(hold);
        pad_n[b] = 1'b1;
        cyc(8);
    endtask

    task automatic async_reset(input string tag);
        #2 resetn = 1'b0;
        #1;
        check({tag, "_rst_dir_out"}, 32'(dir_out), 32'd5);
        check({tag, "_rst_pending"}, 32'(dir_pending), 32'd5);
        check({tag, "_rst_valid"}, 32'(dir_valid), 32'd0);
        check({tag, "_rst_changed"}, 32'(dir_changed), 32'd0);
        check({tag, "_rst_btn"}, 32'(btn_level), 32'd0);
        cyc(2);
        resetn = 1'b1;
    endtask

    initial begin
        pad_n  = 4'hF;
        tick   = 1'b0;
        resetn = 1'b0;
        cyc(3);
        check("reset_dir_out", 32'(dir_out), 32'd5);
        check("reset_btn", 32'(btn_level), 32'd0);
        resetn = 1'b1;

        // Idle ticks
        repeat (20) pulse_tick();
        check("idle_dir_out", 32'(dir_out), 32'd5);
        check("idle_pending", 32'(dir_pending), 32'd5);
        check("idle_valid", 32'(dir_valid), 32'd0);

        // First press and latency
        pad_n[0] = 1'b0;
        cyc(5);
        check("lat_btn_before", 32'(btn_level[0]), 32'd0);
        cyc(1);
        check("lat_btn_at", 32'(btn_level[0]), 32'd1);
        check("lat_pend_before", 32'(dir_pending), 32'd5);
        cyc(1);
        check("lat_pend_after", 32'(dir_pending), 32'd1);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("first_out", 32'(dir_out), 32'd1);
        check("first_valid", 32'(dir_valid), 32'd1);
        check("first_changed", 32'(dir_changed), 32'd1);
        cyc(1);
        check("first_changed_end", 32'(dir_changed), 32'd0);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("second_tick_changed", 32'(dir_changed), 32'd0);
        pad_n[0] = 1'b1;
        cyc(8);

        // Bounce rejection
        for (int k = 0; k < 5; k++) begin
            pad_n[1] = 1'b0;
            cyc(3);
            pad_n[1] = 1'b1;
            cyc(3);
        end
        check("bounce_btn", 32'(btn_level), 32'd0);
        check("bounce_pend", 32'(dir_pending), 32'd1);
        press_release(1, 10);
        check("clean_right_pend", 32'(dir_pending), 32'd2);

        // Reversal
        pulse_tick();
        check("rev_out2", 32'(dir_out), 32'd2);
        press_release(3, 10);
        check("rev_left_rejected", 32'(dir_pending), 32'd2);
        press_release(0, 10);
        check("rev_up_pend", 32'(dir_pending), 32'd1);
        press_release(2, 10);
        check("rev_down_pend", 32'(dir_pending), 32'd3);
        pulse_tick();
        check("rev_out3", 32'(dir_out), 32'd3);

        // Simultaneous presses from idle
        async_reset("simul");
        pad_n[0] = 1'b0;
        pad_n[3] = 1'b0;
        cyc(10);
        check("simul_pend", 32'(dir_pending), 32'd1);
        pulse_tick();
        check("simul_out", 32'(dir_out), 32'd1);
        pad_n = 4'hF;
        cyc(8);
        press_release(2, 10);
        check("simul_down_rejected", 32'(dir_pending), 32'd1);

        // Tick/press collision then async reset
        press_release(1, 10);
        check("coll_pend2", 32'(dir_pending), 32'd2);
        pad_n[3] = 1'b0;
        cyc(6);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("coll_out", 32'(dir_out), 32'd2);
        check("coll_pend", 32'(dir_pending), 32'd2);
        pad_n[3] = 1'b1;
        cyc(8);
        press_release(2, 10);
        check("coll_down_pend", 32'(dir_pending), 32'd3);
        async_reset("coll");
        pulse_tick();
        check("post_reset_out", 32'(dir_out), 32'd5);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 11) == 0) pad_n[b] = ~pad_n[b];
            tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 599) == 0) async_reset("rand");
        end
        tick = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
